alu_issue: RTL and testbench
============================

# alu_issue

Execute-stage issue register for the RISC-toy core. Accepts one decoded instruction per cycle from decode, translates the 5-bit opcode into the 4-bit ALU operation code, selects and forwards operands, and presents registered `ALUOP_E`/`ALUSRC1`/`ALUSRC2` to the ALU. Owns the load-use interlock and the decode→execute stall/flush handshake.

## Interface
- No parameters; all widths fixed: 32-bit data, 5-bit register address.
- `CLK` in 1: single clock, rising edge.
- `RSTN` in 1: asynchronous, active-low reset.
- `VALID_D` in 1: decode presents an instruction.
- `READY_D` out 1: issue accepts this cycle (combinational).
- `OP_D` in 5: RISC-toy opcode.
- `RA1_D`, `RA2_D` in 5: source register addresses; `USE1_D`, `USE2_D` in 1: source actually read.
- `RD1_D`, `RD2_D` in 32: register-file read data.
- `IMM_D` in 32: sign/zero-extended immediate; `IMM_SEL_D` in 1: SRC2 = immediate.
- `WA_D` in 5, `WE_D` in 1: destination of incoming instruction.
- `WA_M`, `WE_M`, `WD_M` in 5/1/32: memory-stage write-back candidate.
- `WA_W`, `WE_W`, `WD_W` in 5/1/32: write-back-stage write.
- `STALL_E` in 1: execute must hold its contents.
- `FLUSH` in 1: kill the E-stage entry (branch taken).
- `VALID_E` out 1; `ALUOP_E` out 4; `ALUSRC1`, `ALUSRC2` out 32; `WA_E` out 5; `WE_E` out 1; `LD_E` out 1 (E entry is a load).

## Operation
- Opcode → `ALUOP_E`: ADDI(0)/ADD(4)/LD(19)/LDR(20)/ST(21)/STR(22)→1; SUB(5)→2; NEG(6)→3; NOT(7)→4; ANDI(1)/AND(8)→5; ORI(2)/OR(9)→6; XOR(10)→7; LSR(11)→8; ASR(12)→9; SHL(13)→10; ROR(14)→11; MOVI(3)→12; all others (branches, jumps, 23-31)→0.
- `LD_E` set for opcodes 19, 20 only.
- Operand n (n=1,2) forward priority: M hit (`WE_M` & `WA_M`==RAn) → `WD_M`; else W hit → `WD_W`; else `RDn_D`. SRC2 then replaced by `IMM_D` when `IMM_SEL_D`=1.
- Forward compare only when `USEn_D`=1; r0 is an ordinary register (no zero special-case).
- Load-use hazard: `VALID_E` & `LD_E` & `WE_E` & ((`USE1_D` & `WA_E`==`RA1_D`) | (`USE2_D` & `WA_E`==`RA2_D`)).
- `READY_D` = ~`STALL_E` & ~hazard.
- Capture when `VALID_D` & `READY_D`: register all E outputs, `VALID_E`=1.
- Hazard & ~`STALL_E`: insert bubble (`VALID_E`=0, `WE_E`=0, `LD_E`=0, `ALUOP_E`=0); decode holds.
- ~`VALID_D` & ~`STALL_E`: bubble as above.
- `STALL_E`=1: all E outputs hold; operands are not re-forwarded.

## Timing
- Reset: every output register 0 (`VALID_E`, `ALUOP_E`, `ALUSRC1`, `ALUSRC2`, `WA_E`, `WE_E`, `LD_E`); asserting `RSTN` mid-stream clears immediately, no clock needed.
- Latency 1 cycle decode→E; throughput 1/cycle absent hazards.
- `FLUSH` priority over all: next edge forces bubble regardless of `STALL_E`, `VALID_D`, hazard; `READY_D` unaffected by `FLUSH` (decode flushed separately).
- Load-use costs exactly one bubble: next cycle the load has left E, hazard clears.
- Simultaneous `STALL_E` and hazard: hold (stall wins), `READY_D`=0.
- M and W both hit same register: M value wins.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding muxes as above.
- Undefined: no forwarding; operands always `RDn_D`; hazard additionally true on any used-source match with (`WE_M`,`WA_M`) or (`WE_W`,`WA_W`), stalling decode until the writer retires. Load-use rule unchanged.

## Test plan
- Reset then ADD(4) r1=5,r2=7, no hits → next cycle `VALID_E`=1, `ALUOP_E`=1, `ALUSRC1`=5, `ALUSRC2`=7.
- ROR(14) with `IMM_SEL_D`=1, `IMM_D`=3 → `ALUOP_E`=11, `ALUSRC2`=3; MOVI(3) → `ALUOP_E`=12; BR(15) → 0.
- RA1=4, `WE_M`/`WA_M`=4/`WD_M`=0xAA, `WE_W`/`WA_W`=4/`WD_W`=0xBB → `ALUSRC1`=0xAA; M disabled → 0xBB (macro defined).
- LD(19) to r3 then SUB using r3 → `READY_D`=0 one cycle, one bubble (`VALID_E`=0, `ALUOP_E`=0), then SUB issues `ALUOP_E`=2.
- `STALL_E`=1 for 3 cycles with changing decode inputs → E outputs frozen, `READY_D`=0; `FLUSH` during stall → `VALID_E`=0 next edge.
- `RSTN` low mid-stream with `VALID_E`=1 → all outputs 0 before next edge.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: decode -> execute issue bundle for the RISC-toy core.
//   master: decode/hazard side. Drives the decoded instruction, the M/W
//           write-back candidates, STALL_E and FLUSH. Receives READY_D and the E-stage fields.
//   slave : alu_issue. Receives the decode, M/W, STALL_E and FLUSH signals.
//           Drives READY_D (combinational) and the registered E-stage outputs.
interface alu_issue_if;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned OPW  = 5;
  localparam int unsigned ALUW = 4;

  logic            VALID_D;
  logic            READY_D;
  logic [OPW-1:0]  OP_D;
  logic [AW-1:0]   RA1_D;
  logic [AW-1:0]   RA2_D;
  logic            USE1_D;
  logic            USE2_D;
  logic [DW-1:0]   RD1_D;
  logic [DW-1:0]   RD2_D;
  logic [DW-1:0]   IMM_D;
  logic            IMM_SEL_D;
  logic [AW-1:0]   WA_D;
  logic            WE_D;
  logic [AW-1:0]   WA_M;
  logic            WE_M;
  logic [DW-1:0]   WD_M;
  logic [AW-1:0]   WA_W;
  logic            WE_W;
  logic [DW-1:0]   WD_W;
  logic            STALL_E;
  logic            FLUSH;
  logic            VALID_E;
  logic [ALUW-1:0] ALUOP_E;
  logic [DW-1:0]   ALUSRC1;
  logic [DW-1:0]   ALUSRC2;
  logic [AW-1:0]   WA_E;
  logic            WE_E;
  logic            LD_E;

  modport master (
    output VALID_D, OP_D, RA1_D, RA2_D, USE1_D, USE2_D, RD1_D, RD2_D,
           IMM_D, IMM_SEL_D, WA_D, WE_D, WA_M, WE_M, WD_M, WA_W, WE_W, WD_W,
           STALL_E, FLUSH,
    input  READY_D, VALID_E, ALUOP_E, ALUSRC1, ALUSRC2, WA_E, WE_E, LD_E
  );

  modport slave (
    input  VALID_D, OP_D, RA1_D, RA2_D, USE1_D, USE2_D, RD1_D, RD2_D,
           IMM_D, IMM_SEL_D, WA_D, WE_D, WA_M, WE_M, WD_M, WA_W, WE_W, WD_W,
           STALL_E, FLUSH,
    output READY_D, VALID_E, ALUOP_E, ALUSRC1, ALUSRC2, WA_E, WE_E, LD_E
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: execute-stage issue register for the RISC-toy core.
// Decodes the opcode into the ALU op and selects and forwards the operands.
// It also owns the load-use interlock and the stall/flush handshake.
// Ports: CLK, RSTN (async active-low), bus (alu_issue_if.slave).
// Option: define ALU_ISSUE_FWD_EN to enable M/W operand forwarding. Without
// it, operands come straight from the register file and decode interlocks
// on any pending M/W writer of a used source.
module alu_issue (
  input logic        CLK,
  input logic        RSTN,
  alu_issue_if.slave bus
);
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned ALUW = 4;

  logic [ALUW-1:0] r_aluop, w_nxt_aluop, w_aluop;
  logic [DW-1:0]   r_src1, w_nxt_src1, w_src1;
  logic [DW-1:0]   r_src2, w_nxt_src2, w_src2;
  logic [AW-1:0]   r_wa, w_nxt_wa;
  logic            r_valid, w_nxt_valid;
  logic            r_we, w_nxt_we;
  logic            r_ld, w_nxt_ld, w_ld;
  logic            w_load_use, w_raw, w_hazard;

  // Opcode translation to the ALU operation code
  always_comb begin
    w_aluop = ALUW'(0);
    unique case (bus.OP_D)
      5'd0, 5'd4, 5'd19, 5'd20, 5'd21, 5'd22: w_aluop = ALUW'(1);
      5'd5:        w_aluop = ALUW'(2);
      5'd6:        w_aluop = ALUW'(3);
      5'd7:        w_aluop = ALUW'(4);
      5'd1, 5'd8:  w_aluop = ALUW'(5);
      5'd2, 5'd9:  w_aluop = ALUW'(6);
      5'd10:       w_aluop = ALUW'(7);
      5'd11:       w_aluop = ALUW'(8);
      5'd12:       w_aluop = ALUW'(9);
      5'd13:       w_aluop = ALUW'(10);
      5'd14:       w_aluop = ALUW'(11);
      5'd3:        w_aluop = ALUW'(12);
      default:     w_aluop = ALUW'(0);
    endcase
  end

  assign w_ld = (bus.OP_D == 5'd19) || (bus.OP_D == 5'd20);

  // A load sitting in E cannot supply its data to a dependent instruction in time
  assign w_load_use = r_valid && r_ld && r_we &&
                      ((bus.USE1_D && (r_wa == bus.RA1_D)) ||
                       (bus.USE2_D && (r_wa == bus.RA2_D)));

`ifdef ALU_ISSUE_FWD_EN
  // Operand select: the M stage is younger than W, so M takes priority
  always_comb begin
    w_src1 = bus.RD1_D;
    if (bus.USE1_D && bus.WE_M && (bus.WA_M == bus.RA1_D))      w_src1 = bus.WD_M;
    else if (bus.USE1_D && bus.WE_W && (bus.WA_W == bus.RA1_D)) w_src1 = bus.WD_W;

    w_src2 = bus.RD2_D;
    if (bus.USE2_D && bus.WE_M && (bus.WA_M == bus.RA2_D))      w_src2 = bus.WD_M;
    else if (bus.USE2_D && bus.WE_W && (bus.WA_W == bus.RA2_D)) w_src2 = bus.WD_W;
    if (bus.IMM_SEL_D) w_src2 = bus.IMM_D;
  end

  assign w_raw = 1'b0;
`else
  // No bypass: hold decode until any pending writer of a used source retires
  logic w_unused_wd;
  assign w_unused_wd = ^{bus.WD_M, bus.WD_W};

  assign w_src1 = bus.RD1_D;
  assign w_src2 = bus.IMM_SEL_D ? bus.IMM_D : bus.RD2_D;
  assign w_raw  = (bus.USE1_D && ((bus.WE_M && (bus.WA_M == bus.RA1_D)) ||
                                  (bus.WE_W && (bus.WA_W == bus.RA1_D)))) ||
                  (bus.USE2_D && ((bus.WE_M && (bus.WA_M == bus.RA2_D)) ||
                                  (bus.WE_W && (bus.WA_W == bus.RA2_D))));
`endif

  assign w_hazard    = w_load_use || w_raw;
  assign bus.READY_D = !bus.STALL_E && !w_hazard;

  // Next E contents: flush beats stall, stall holds, otherwise capture or bubble
  always_comb begin
    w_nxt_valid = r_valid;
    w_nxt_aluop = r_aluop;
    w_nxt_src1  = r_src1;
    w_nxt_src2  = r_src2;
    w_nxt_wa    = r_wa;
    w_nxt_we    = r_we;
    w_nxt_ld    = r_ld;
    if (bus.FLUSH || (!bus.STALL_E && !(bus.VALID_D && !w_hazard))) begin
      w_nxt_valid = 1'b0;
      w_nxt_aluop = ALUW'(0);
      w_nxt_we    = 1'b0;
      w_nxt_ld    = 1'b0;
    end else if (!bus.STALL_E) begin
      w_nxt_valid = 1'b1;
      w_nxt_aluop = w_aluop;
      w_nxt_src1  = w_src1;
      w_nxt_src2  = w_src2;
      w_nxt_wa    = bus.WA_D;
      w_nxt_we    = bus.WE_D;
      w_nxt_ld    = w_ld;
    end
  end

  // E-stage register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_valid <= 1'b0;
      r_aluop <= ALUW'(0);
      r_src1  <= DW'(0);
      r_src2  <= DW'(0);
      r_wa    <= AW'(0);
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
    end else begin
      r_valid <= w_nxt_valid;
      r_aluop <= w_nxt_aluop;
      r_src1  <= w_nxt_src1;
      r_src2  <= w_nxt_src2;
      r_wa    <= w_nxt_wa;
      r_we    <= w_nxt_we;
      r_ld    <= w_nxt_ld;
    end
  end

  assign bus.VALID_E = r_valid;
  assign bus.ALUOP_E = r_aluop;
  assign bus.ALUSRC1 = r_src1;
  assign bus.ALUSRC2 = r_src2;
  assign bus.WA_E    = r_wa;
  assign bus.WE_E    = r_we;
  assign bus.LD_E    = r_ld;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue.
// It runs an opcode/operand vector table and then hand-written sequences for
// forwarding, load-use, stall, flush and mid-stream reset. Expected E-stage
// contents go into a queue when stimulus is driven and are compared after the edge.
module tb_alu_issue;
  logic CLK = 1'b0;
  logic RSTN;

  alu_issue_if bus ();

  alu_issue dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  op, ra1, ra2;
    logic        u1, u2;
    logic [31:0] rd1, rd2, imm;
    logic        isel;
    logic [4:0]  wa;
    logic        we;
    logic [3:0]  e_aluop;
    logic [31:0] e_src1, e_src2;
    logic        e_ld;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [3:0]  aluop;
    logic [31:0] src1, src2;
    logic [4:0]  wa;
    logic        we, ld;
    logic        data;  // compare operand/destination fields too
  } exp_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tbl[23];

  function automatic vec_t mk(input logic [4:0] op, ra1, ra2, input logic u1, u2,
                              input logic [31:0] rd1, rd2, imm, input logic isel,
                              input logic [4:0] wa, input logic we, input logic [3:0] eop,
                              input logic [31:0] es1, es2, input logic eld);
    vec_t v;
    v.op = op; v.ra1 = ra1; v.ra2 = ra2; v.u1 = u1; v.u2 = u2;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.isel = isel; v.wa = wa; v.we = we;
    v.e_aluop = eop; v.e_src1 = es1; v.e_src2 = es2; v.e_ld = eld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic set_dec(input logic [4:0] op, ra1, ra2, input logic u1, u2,
                         input logic [31:0] rd1, rd2, imm, input logic isel,
                         input logic [4:0] wa, input logic we);
    bus.VALID_D = 1'b1; bus.OP_D = op; bus.RA1_D = ra1; bus.RA2_D = ra2;
    bus.USE1_D = u1; bus.USE2_D = u2; bus.RD1_D = rd1; bus.RD2_D = rd2;
    bus.IMM_D = imm; bus.IMM_SEL_D = isel; bus.WA_D = wa; bus.WE_D = we;
  endtask

  task automatic push(input logic v, input logic [3:0] op, input logic [31:0] s1, s2,
                      input logic [4:0] wa, input logic we, ld, input logic data);
    exp_t e;
    e.valid = v; e.aluop = op; e.src1 = s1; e.src2 = s2;
    e.wa = wa; e.we = we; e.ld = ld; e.data = data;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one edge and compare E outputs with the oldest expectation
  task automatic step_check(input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s.sb: actual=empty required=entry", tag);
    end else begin
      n_chk--;
      e = sb.pop_front();
      chk({tag, ".valid"}, 32'(bus.VALID_E), 32'(e.valid));
      chk({tag, ".aluop"}, 32'(bus.ALUOP_E), 32'(e.aluop));
      chk({tag, ".we"},    32'(bus.WE_E),    32'(e.we));
      chk({tag, ".ld"},    32'(bus.LD_E),    32'(e.ld));
      if (e.data) begin
        chk({tag, ".src1"}, bus.ALUSRC1, e.src1);
        chk({tag, ".src2"}, bus.ALUSRC2, e.src2);
        chk({tag, ".wa"},   32'(bus.WA_E), 32'(e.wa));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(bus.VALID_E), 32'd0);
    chk({tag, ".aluop"}, 32'(bus.ALUOP_E), 32'd0);
    chk({tag, ".src1"},  bus.ALUSRC1, 32'd0);
    chk({tag, ".src2"},  bus.ALUSRC2, 32'd0);
    chk({tag, ".wa"},    32'(bus.WA_E), 32'd0);
    chk({tag, ".we"},    32'(bus.WE_E), 32'd0);
    chk({tag, ".ld"},    32'(bus.LD_E), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 op   ra1 ra2 u1 u2 rd1            rd2         imm          is  wa  we  aluop src1           src2          ld
    tbl[0]  = mk(5'd4,  1, 2, 1, 1, 32'd5,         32'd7,      32'd0,       0, 5,  1, 4'd1,  32'd5,         32'd7,        0);
    tbl[1]  = mk(5'd14, 1, 2, 1, 0, 32'h80000001,  32'd9,      32'd3,       1, 6,  1, 4'd11, 32'h80000001,  32'd3,        0);
    tbl[2]  = mk(5'd3,  0, 0, 0, 0, 32'hDEAD,      32'hBEEF,   32'h1234,    1, 7,  1, 4'd12, 32'hDEAD,      32'h1234,     0);
    tbl[3]  = mk(5'd15, 1, 2, 1, 1, 32'd1,         32'd2,      32'h40,      1, 0,  0, 4'd0,  32'd1,         32'h40,       0);
    tbl[4]  = mk(5'd19, 1, 0, 1, 0, 32'h100,       32'd0,      32'd8,       1, 20, 1, 4'd1,  32'h100,       32'd8,        1);
    tbl[5]  = mk(5'd5,  1, 2, 1, 1, 32'd10,        32'd3,      32'd0,       0, 8,  1, 4'd2,  32'd10,        32'd3,        0);
    tbl[6]  = mk(5'd6,  2, 0, 1, 0, 32'd4,         32'd0,      32'd0,       0, 9,  1, 4'd3,  32'd4,         32'd0,        0);
    tbl[7]  = mk(5'd7,  2, 0, 1, 0, 32'hF0,        32'd0,      32'd0,       0, 9,  1, 4'd4,  32'hF0,        32'd0,        0);
    tbl[8]  = mk(5'd8,  1, 2, 1, 1, 32'hFF,        32'h0F,     32'd0,       0, 9,  1, 4'd5,  32'hFF,        32'h0F,       0);
    tbl[9]  = mk(5'd1,  1, 0, 1, 0, 32'hFF,        32'd0,      32'h3C,      1, 9,  1, 4'd5,  32'hFF,        32'h3C,       0);
    tbl[10] = mk(5'd9,  1, 2, 1, 1, 32'h11,        32'h22,     32'd0,       0, 10, 1, 4'd6,  32'h11,        32'h22,       0);
    tbl[11] = mk(5'd2,  1, 0, 1, 0, 32'h11,        32'd0,      32'h5,       1, 10, 1, 4'd6,  32'h11,        32'h5,        0);
    tbl[12] = mk(5'd10, 1, 2, 1, 1, 32'hA5,        32'h5A,     32'd0,       0, 11, 1, 4'd7,  32'hA5,        32'h5A,       0);
    tbl[13] = mk(5'd11, 1, 2, 1, 1, 32'h80,        32'd2,      32'd0,       0, 11, 1, 4'd8,  32'h80,        32'd2,        0);
    tbl[14] = mk(5'd12, 1, 2, 1, 1, 32'h80000000,  32'd4,      32'd0,       0, 12, 1, 4'd9,  32'h80000000,  32'd4,        0);
    tbl[15] = mk(5'd13, 1, 2, 1, 1, 32'd1,         32'd31,     32'd0,       0, 12, 1, 4'd10, 32'd1,         32'd31,       0);
    tbl[16] = mk(5'd20, 1, 2, 1, 1, 32'h300,       32'h4,      32'd0,       0, 21, 1, 4'd1,  32'h300,       32'h4,        1);
    tbl[17] = mk(5'd21, 1, 2, 1, 1, 32'h400,       32'h44,     32'h10,      1, 0,  0, 4'd1,  32'h400,       32'h10,       0);
    tbl[18] = mk(5'd22, 1, 2, 1, 1, 32'h500,       32'h55,     32'd0,       0, 0,  0, 4'd1,  32'h500,       32'h55,       0);
    tbl[19] = mk(5'd23, 1, 2, 1, 1, 32'd6,         32'd7,      32'd0,       0, 0,  0, 4'd0,  32'd6,         32'd7,        0);
    tbl[20] = mk(5'd31, 1, 2, 1, 1, 32'd8,         32'd9,      32'd0,       0, 0,  0, 4'd0,  32'd8,         32'd9,        0);
    tbl[21] = mk(5'd0,  1, 0, 1, 0, 32'd100,       32'd0,      32'hFFFFFFFF,1, 13, 1, 4'd1,  32'd100,       32'hFFFFFFFF, 0);
    tbl[22] = mk(5'd16, 1, 2, 1, 1, 32'd3,         32'd4,      32'd0,       0, 0,  0, 4'd0,  32'd3,         32'd4,        0);

    RSTN = 1'b1;
    bus.VALID_D = 0; bus.OP_D = 0; bus.RA1_D = 0; bus.RA2_D = 0;
    bus.USE1_D = 0; bus.USE2_D = 0; bus.RD1_D = 0; bus.RD2_D = 0;
    bus.IMM_D = 0; bus.IMM_SEL_D = 0; bus.WA_D = 0; bus.WE_D = 0;
    bus.WA_M = 0; bus.WE_M = 0; bus.WD_M = 0;
    bus.WA_W = 0; bus.WE_W = 0; bus.WD_W = 0;
    bus.STALL_E = 0; bus.FLUSH = 0;

    // Reset state
    #2 RSTN = 1'b0;
    #1;
    chk_all_zero("rst");
    chk("rst.ready", 32'(bus.READY_D), 32'd1);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTN = 1'b1;
    @(posedge CLK);
    #1;

    // Opcode/operand table, back-to-back issue
    for (int i = 0; i < 23; i++) begin
      set_dec(tbl[i].op, tbl[i].ra1, tbl[i].ra2, tbl[i].u1, tbl[i].u2,
              tbl[i].rd1, tbl[i].rd2, tbl[i].imm, tbl[i].isel, tbl[i].wa, tbl[i].we);
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(bus.READY_D), 32'd1);
      push(1'b1, tbl[i].e_aluop, tbl[i].e_src1, tbl[i].e_src2, tbl[i].wa,
           tbl[i].we, tbl[i].e_ld, 1'b1);
      step_check($sformatf("vec%0d", i));
    end

    // Both M and W write r4
    set_dec(5'd4, 5'd4, 5'd2, 1, 1, 32'h11, 32'h22, 32'd0, 0, 5'd9, 1);
    bus.WE_M = 1; bus.WA_M = 5'd4; bus.WD_M = 32'hAA;
    bus.WE_W = 1; bus.WA_W = 5'd4; bus.WD_W = 32'hBB;
    #1;
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd_mw.ready", 32'(bus.READY_D), 32'd1);
    push(1'b1, 4'd1, 32'hAA, 32'h22, 5'd9, 1'b1, 1'b0, 1'b1);
    step_check("fwd_mw");
    bus.WE_M = 0;
    #1;
    chk("fwd_w.ready", 32'(bus.READY_D), 32'd1);
    push(1'b1, 4'd1, 32'hBB, 32'h22, 5'd9, 1'b1, 1'b0, 1'b1);
    step_check("fwd_w");
    bus.WA_W = 5'd2; bus.IMM_SEL_D = 1; bus.IMM_D = 32'h77;
    #1;
    push(1'b1, 4'd1, 32'h11, 32'h77, 5'd9, 1'b1, 1'b0, 1'b1);
    step_check("fwd_imm");
`else
    chk("raw_mw.ready", 32'(bus.READY_D), 32'd0);
    push_bubble();
    step_check("raw_mw");
    bus.WE_M = 0;
    #1;
    chk("raw_w.ready", 32'(bus.READY_D), 32'd0);
    push_bubble();
    step_check("raw_w");
    bus.WE_W = 0;
    #1;
    chk("raw_clr.ready", 32'(bus.READY_D), 32'd1);
    push(1'b1, 4'd1, 32'h11, 32'h22, 5'd9, 1'b1, 1'b0, 1'b1);
    step_check("raw_clr");
`endif
    bus.WE_M = 0; bus.WE_W = 0;

    // Load-use: exactly one bubble
    set_dec(5'd19, 5'd1, 5'd0, 1, 0, 32'h200, 32'd0, 32'd4, 1, 5'd3, 1);
    #1;
    push(1'b1, 4'd1, 32'h200, 32'd4, 5'd3, 1'b1, 1'b1, 1'b1);
    step_check("lu_ld");
    set_dec(5'd5, 5'd3, 5'd2, 1, 1, 32'h50, 32'h10, 32'd0, 0, 5'd4, 1);
    #1;
    chk("lu.ready_hz", 32'(bus.READY_D), 32'd0);
    push_bubble();
    step_check("lu_bubble");
    chk("lu.ready_clr", 32'(bus.READY_D), 32'd1);
    push(1'b1, 4'd2, 32'h50, 32'h10, 5'd4, 1'b1, 1'b0, 1'b1);
    step_check("lu_sub");

    // Stall together with a load-use hazard: stall wins
    set_dec(5'd19, 5'd1, 5'd0, 1, 0, 32'h200, 32'd0, 32'd4, 1, 5'd3, 1);
    #1;
    push(1'b1, 4'd1, 32'h200, 32'd4, 5'd3, 1'b1, 1'b1, 1'b1);
    step_check("sh_ld");
    set_dec(5'd5, 5'd3, 5'd2, 1, 1, 32'h50, 32'h10, 32'd0, 0, 5'd4, 1);
    bus.STALL_E = 1;
    #1;
    chk("sh.ready", 32'(bus.READY_D), 32'd0);
    push(1'b1, 4'd1, 32'h200, 32'd4, 5'd3, 1'b1, 1'b1, 1'b1);
    step_check("sh_hold");
    bus.STALL_E = 0;
    #1;
    push_bubble();
    step_check("sh_bubble");

    // Three-cycle stall with changing decode inputs, then flush during stall
    set_dec(5'd4, 5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'd0, 0, 5'd5, 1);
    #1;
    push(1'b1, 4'd1, 32'd5, 32'd7, 5'd5, 1'b1, 1'b0, 1'b1);
    step_check("st_add");
    bus.STALL_E = 1;
    for (int k = 0; k < 3; k++) begin
      set_dec(5'(8 + k), 5'(k + 6), 5'(k + 7), 1, 1, $urandom, $urandom,
              $urandom, 1'(k), 5'(k + 20), 1);
      #1;
      chk($sformatf("st%0d.ready", k), 32'(bus.READY_D), 32'd0);
      push(1'b1, 4'd1, 32'd5, 32'd7, 5'd5, 1'b1, 1'b0, 1'b1);
      step_check($sformatf("st%0d", k));
    end
    bus.FLUSH = 1;
    #1;
    push_bubble();
    step_check("st_flush");

    // Flush with a ready decode: READY_D stays high, E still bubbles
    bus.STALL_E = 0;
    set_dec(5'd4, 5'd1, 5'd2, 1, 1, 32'd1, 32'd2, 32'd0, 0, 5'd6, 1);
    #1;
    chk("fl.ready", 32'(bus.READY_D), 32'd1);
    push_bubble();
    step_check("fl_bubble");
    bus.FLUSH = 0;

    // Idle decode produces a bubble
    bus.VALID_D = 0;
    #1;
    push_bubble();
    step_check("idle");

    // Mid-stream reset clears without a clock
    set_dec(5'd13, 5'd1, 5'd2, 1, 1, 32'h9, 32'h3, 32'd0, 0, 5'd7, 1);
    #1;
    push(1'b1, 4'd10, 32'h9, 32'h3, 5'd7, 1'b1, 1'b0, 1'b1);
    step_check("mr_pre");
    RSTN = 1'b0;
    #1;
    chk_all_zero("mrst");
    bus.VALID_D = 0;
    @(negedge CLK) RSTN = 1'b1;
    @(posedge CLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
